dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port (DataMemory data side) between two requesters: the CPU data port (d_mem_*) and the CDMA engine (cdma_*).
- Sits between PipelineCPU / CDMA and the memory.
- Grants one whole transaction at a time, with round-robin fairness.
- Has a per-transaction timeout, so a stuck memory cannot hang either requester.

---
 rtl/dmem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Round-robin whole-transaction arbiter sharing one data-memory port between the CPU and CDMA,
// with a per-transaction timeout. Optional performance counters: define DMEM_ARB_PERF_EN.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned TO_W    = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_rd_en,
    input  logic              cpu_wr_en,
    input  logic [3:0]        cpu_ctrl,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_available,
    output logic              cpu_err,
    input  logic              dma_rd_en,
    input  logic              dma_wr_en,
    input  logic [3:0]        dma_ctrl,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wr_data,
    output logic [DATA_W-1:0] dma_rd_data,
    output logic              dma_available,
    output logic              dma_err,
`ifdef DMEM_ARB_PERF_EN
    input  logic              perf_clr,
    output logic [31:0]       cpu_grant_cnt,
    output logic [31:0]       dma_grant_cnt,
    output logic [31:0]       cpu_wait_cnt,
    output logic [31:0]       dma_wait_cnt,
`endif
    output logic              m_rd_en,
    output logic              m_wr_en,
    output logic [3:0]        m_ctrl,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wr_data,
    input  logic [DATA_W-1:0] m_rd_data,
    input  logic              m_available
);

    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_DMA} state_t;

    state_t          state, state_nxt;
    logic            last_dma, last_dma_nxt;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic            cpu_req, dma_req, owner_req, done, timed_out;

    assign cpu_req = cpu_rd_en | cpu_wr_en;
    assign dma_req = dma_rd_en | dma_wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_dma <= 1'b1;
            to_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            last_dma <= last_dma_nxt;
            to_cnt   <= to_cnt_nxt;
        end
    end

    // Grant selection, port mux, and completion/timeout/abort resolution.
    always_comb begin
        state_nxt     = state;
        last_dma_nxt  = last_dma;
        to_cnt_nxt    = to_cnt;
        owner_req     = 1'b0;
        done          = 1'b0;
        timed_out     = 1'b0;
        m_rd_en       = 1'b0;
        m_wr_en       = 1'b0;
        m_ctrl        = '0;
        m_addr        = '0;
        m_wr_data     = '0;
        cpu_available = 1'b0;
        cpu_err       = 1'b0;
        cpu_rd_data   = '0;
        dma_available = 1'b0;
        dma_err       = 1'b0;
        dma_rd_data   = '0;

        case (state)
            IDLE: begin
                // On a tie the requester that did not win last time is granted.
                if (cpu_req && (!dma_req || last_dma)) begin
                    state_nxt    = OWN_CPU;
                    last_dma_nxt = 1'b0;
                    to_cnt_nxt   = '0;
                end else if (dma_req) begin
                    state_nxt    = OWN_DMA;
                    last_dma_nxt = 1'b1;
                    to_cnt_nxt   = '0;
                end
            end
            OWN_CPU: begin
                owner_req = cpu_req;
                m_wr_en   = cpu_wr_en;
                m_rd_en   = cpu_rd_en & ~cpu_wr_en;
                m_ctrl    = cpu_ctrl;
                m_addr    = cpu_addr;
                m_wr_data = cpu_wr_data;
            end
            OWN_DMA: begin
                owner_req = dma_req;
                m_wr_en   = dma_wr_en;
                m_rd_en   = dma_rd_en & ~dma_wr_en;
                m_ctrl    = dma_ctrl;
                m_addr    = dma_addr;
                m_wr_data = dma_wr_data;
            end
            default: state_nxt = IDLE;
        endcase

        if (state == OWN_CPU || state == OWN_DMA) begin
            if (!owner_req) begin
                state_nxt = IDLE;
            end else if (m_available) begin
                done      = 1'b1;
                state_nxt = IDLE;
            end else if (TO_EN && (to_cnt == TO_LAST)) begin
                timed_out = 1'b1;
                state_nxt = IDLE;
            end else begin
                to_cnt_nxt = to_cnt + 1'b1;
            end
        end

        if (state == OWN_CPU) begin
            cpu_available = done | timed_out;
            cpu_err       = timed_out;
            cpu_rd_data   = done ? m_rd_data : '0;
        end
        if (state == OWN_DMA) begin
            dma_available = done | timed_out;
            dma_err       = timed_out;
            dma_rd_data   = done ? m_rd_data : '0;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic cpu_grant_inc, dma_grant_inc, cpu_wait_inc, dma_wait_inc;

    assign cpu_grant_inc = (state == IDLE) && (state_nxt == OWN_CPU);
    assign dma_grant_inc = (state == IDLE) && (state_nxt == OWN_DMA);
    assign cpu_wait_inc  = cpu_req && (state != OWN_CPU);
    assign dma_wait_inc  = dma_req && (state != OWN_DMA);

    // Saturating event counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_grant_cnt <= '0;
            dma_grant_cnt <= '0;
            cpu_wait_cnt  <= '0;
            dma_wait_cnt  <= '0;
        end else if (perf_clr) begin
            cpu_grant_cnt <= '0;
            dma_grant_cnt <= '0;
            cpu_wait_cnt  <= '0;
            dma_wait_cnt  <= '0;
        end else begin
            if (cpu_grant_inc && (cpu_grant_cnt != '1)) cpu_grant_cnt <= cpu_grant_cnt + 32'd1;
            if (dma_grant_inc && (dma_grant_cnt != '1)) dma_grant_cnt <= dma_grant_cnt + 32'd1;
            if (cpu_wait_inc && (cpu_wait_cnt != '1))   cpu_wait_cnt  <= cpu_wait_cnt + 32'd1;
            if (dma_wait_inc && (dma_wait_cnt != '1))   dma_wait_cnt  <= dma_wait_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed testbench for dmem_port_arbiter (TIMEOUT=8); inputs change 1 time unit after posedge.
module tb_dmem_port_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam logic [31:0] CPU_A  = 32'h0000_1000;
    localparam logic [31:0] DMA_A  = 32'h0000_2000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_rd_en, cpu_wr_en, dma_rd_en, dma_wr_en;
    logic [3:0]        cpu_ctrl, dma_ctrl, m_ctrl;
    logic [ADDR_W-1:0] cpu_addr, dma_addr, m_addr;
    logic [DATA_W-1:0] cpu_wr_data, dma_wr_data, cpu_rd_data, dma_rd_data;
    logic [DATA_W-1:0] m_wr_data, m_rd_data;
    logic              cpu_available, cpu_err, dma_available, dma_err;
    logic              m_rd_en, m_wr_en, m_available;
`ifdef DMEM_ARB_PERF_EN
    logic              perf_clr;
    logic [31:0]       cpu_grant_cnt, dma_grant_cnt, cpu_wait_cnt, dma_wait_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8), .TO_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_ctrl(cpu_ctrl),
        .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
        .cpu_available(cpu_available), .cpu_err(cpu_err),
        .dma_rd_en(dma_rd_en), .dma_wr_en(dma_wr_en), .dma_ctrl(dma_ctrl),
        .dma_addr(dma_addr), .dma_wr_data(dma_wr_data), .dma_rd_data(dma_rd_data),
        .dma_available(dma_available), .dma_err(dma_err),
`ifdef DMEM_ARB_PERF_EN
        .perf_clr(perf_clr), .cpu_grant_cnt(cpu_grant_cnt), .dma_grant_cnt(dma_grant_cnt),
        .cpu_wait_cnt(cpu_wait_cnt), .dma_wait_cnt(dma_wait_cnt),
`endif
        .m_rd_en(m_rd_en), .m_wr_en(m_wr_en), .m_ctrl(m_ctrl), .m_addr(m_addr),
        .m_wr_data(m_wr_data), .m_rd_data(m_rd_data), .m_available(m_available)
    );

    task automatic clear_inputs();
        cpu_rd_en = 0; cpu_wr_en = 0; cpu_ctrl = 4'h0; cpu_addr = '0; cpu_wr_data = '0;
        dma_rd_en = 0; dma_wr_en = 0; dma_ctrl = 4'h0; dma_addr = '0; dma_wr_data = '0;
        m_rd_data = '0; m_available = 0;
`ifdef DMEM_ARB_PERF_EN
        perf_clr = 0;
`endif
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 unit after the first post-reset edge, arbiter in IDLE.
    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        cpu_rd_en = 1; cpu_addr = CPU_A; dma_wr_en = 1; dma_addr = DMA_A;
        step(); step();
        checks++;
        if ({m_rd_en, m_wr_en} !== 2'b00) begin
            failures++; $display("FAIL reset_enables got=%b exp=00", {m_rd_en, m_wr_en});
        end
        checks++;
        if (m_addr !== 32'h0) begin
            failures++; $display("FAIL reset_addr got=%h exp=00000000", m_addr);
        end
        checks++;
        if ({cpu_available, cpu_err, dma_available, dma_err} !== 4'b0000 ||
            cpu_rd_data !== 32'h0 || dma_rd_data !== 32'h0) begin
            failures++; $display("FAIL reset_resp got=%b/%h/%h exp=0000/0/0",
                {cpu_available, cpu_err, dma_available, dma_err}, cpu_rd_data, dma_rd_data);
        end
        do_reset();
    endtask

    task automatic test_cpu_read();
        do_reset();
        cpu_rd_en = 1; cpu_addr = 32'h100; cpu_ctrl = 4'h2; #1;
        checks++;
        if (m_rd_en !== 1'b0) begin
            failures++; $display("FAIL rd_cycle0_en got=%b exp=0", m_rd_en);
        end
        step();
        checks++;
        if (m_rd_en !== 1'b1 || m_addr !== 32'h100 || m_ctrl !== 4'h2 || cpu_available !== 1'b0) begin
            failures++; $display("FAIL rd_cycle1 got=%b/%h/%h/%b exp=1/100/2/0",
                m_rd_en, m_addr, m_ctrl, cpu_available);
        end
        step();
        m_rd_data = 32'hDEAD_BEEF; m_available = 1; #1;
        checks++;
        if (m_rd_en !== 1'b1 || cpu_available !== 1'b1 || cpu_err !== 1'b0 ||
            cpu_rd_data !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL rd_cycle2 got=%b/%b/%b/%h exp=1/1/0/deadbeef",
                m_rd_en, cpu_available, cpu_err, cpu_rd_data);
        end
        checks++;
        if (dma_available !== 1'b0 || dma_rd_data !== 32'h0) begin
            failures++; $display("FAIL rd_nonowner got=%b/%h exp=0/0", dma_available, dma_rd_data);
        end
        step();
        m_available = 0; cpu_rd_en = 0; #1;
        checks++;
        if (m_rd_en !== 1'b0 || cpu_available !== 1'b0) begin
            failures++; $display("FAIL rd_cycle3 got=%b/%b exp=0/0", m_rd_en, cpu_available);
        end
    endtask

    task automatic test_fairness();
        logic exp_cpu;
        int   waited;
        do_reset();
        cpu_rd_en = 1; cpu_addr = CPU_A; dma_rd_en = 1; dma_addr = DMA_A;
        exp_cpu = 1'b1;
        for (int g = 0; g < 8; g++) begin
            waited = 0;
            do begin
                step(); m_available = 0; #1; waited++;
            end while (!m_rd_en && waited < 6);
            checks++;
            if (m_addr !== (exp_cpu ? CPU_A : DMA_A)) begin
                failures++; $display("FAIL grant_%0d addr got=%h exp=%h", g, m_addr,
                    exp_cpu ? CPU_A : DMA_A);
            end
            m_rd_data = 32'hA000 + 32'(g); m_available = 1; #1;
            checks++;
            if ({cpu_available, dma_available} !== (exp_cpu ? 2'b10 : 2'b01) ||
                (exp_cpu ? cpu_rd_data : dma_rd_data) !== 32'hA000 + 32'(g)) begin
                failures++; $display("FAIL grant_%0d resp got=%b/%h/%h exp_cpu=%b data=%h", g,
                    {cpu_available, dma_available}, cpu_rd_data, dma_rd_data, exp_cpu,
                    32'hA000 + 32'(g));
            end
            exp_cpu = ~exp_cpu;
        end
        step();
        m_available = 0; cpu_rd_en = 0; dma_rd_en = 0;
        step();
    endtask

    task automatic test_write_priority();
        do_reset();
        cpu_rd_en = 1; cpu_wr_en = 1; cpu_addr = 32'h20; cpu_wr_data = 32'h1234_5678; cpu_ctrl = 4'hF;
        step();
        checks++;
        if (m_wr_en !== 1'b1 || m_rd_en !== 1'b0 || m_wr_data !== 32'h1234_5678 ||
            m_addr !== 32'h20 || m_ctrl !== 4'hF) begin
            failures++; $display("FAIL wr_prio got=%b/%b/%h/%h/%h exp=1/0/12345678/20/f",
                m_wr_en, m_rd_en, m_wr_data, m_addr, m_ctrl);
        end
        m_available = 1; #1;
        checks++;
        if (cpu_available !== 1'b1 || cpu_err !== 1'b0) begin
            failures++; $display("FAIL wr_done got=%b/%b exp=1/0", cpu_available, cpu_err);
        end
        step();
        m_available = 0; cpu_rd_en = 0; cpu_wr_en = 0;
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        dma_rd_en = 1; dma_addr = DMA_A; m_rd_data = 32'hAAAA_5555;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k < 8) begin
                checks++;
                if (dma_available !== 1'b0) begin
                    failures++; $display("FAIL to_early k=%0d got=%b exp=0", k, dma_available);
                end
            end else begin
                checks++;
                if ({dma_available, dma_err} !== 2'b11 || dma_rd_data !== 32'h0) begin
                    failures++; $display("FAIL to_fire got=%b/%h exp=11/0",
                        {dma_available, dma_err}, dma_rd_data);
                end
            end
        end
        step();
        checks++;
        if (m_rd_en !== 1'b0) begin
            failures++; $display("FAIL to_idle got=%b exp=0", m_rd_en);
        end
        // Second request answered exactly on the last allowed cycle: a normal completion.
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 8) m_available = 1;
            #1;
            if (k < 8) begin
                checks++;
                if (dma_available !== 1'b0 || m_rd_en !== 1'b1) begin
                    failures++; $display("FAIL to2_wait k=%0d got=%b/%b exp=0/1", k,
                        dma_available, m_rd_en);
                end
            end else begin
                checks++;
                if ({dma_available, dma_err} !== 2'b10 || dma_rd_data !== 32'hAAAA_5555) begin
                    failures++; $display("FAIL to2_done got=%b/%h exp=10/aaaa5555",
                        {dma_available, dma_err}, dma_rd_data);
                end
            end
        end
        step();
        m_available = 0; dma_rd_en = 0;
        step();
    endtask

    task automatic test_abort();
        do_reset();
        cpu_rd_en = 1; cpu_addr = CPU_A;
        step();
        cpu_rd_en = 0; #1;
        checks++;
        if (m_rd_en !== 1'b0 || cpu_available !== 1'b0) begin
            failures++; $display("FAIL abort_drop got=%b/%b exp=0/0", m_rd_en, cpu_available);
        end
        step();
        m_available = 1; #1;
        checks++;
        if (cpu_available !== 1'b0 || dma_available !== 1'b0) begin
            failures++; $display("FAIL abort_late got=%b/%b exp=0/0", cpu_available, dma_available);
        end
        m_available = 0; dma_rd_en = 1; dma_addr = DMA_A;
        step();
        checks++;
        if (m_rd_en !== 1'b1 || m_addr !== DMA_A) begin
            failures++; $display("FAIL abort_next got=%b/%h exp=1/%h", m_rd_en, m_addr, DMA_A);
        end
        m_available = 1; #1;
        step();
        m_available = 0; dma_rd_en = 0;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        dma_rd_en = 1; dma_addr = DMA_A;
        step();
        checks++;
        if (m_rd_en !== 1'b1 || m_addr !== DMA_A) begin
            failures++; $display("FAIL mid_own got=%b/%h exp=1/%h", m_rd_en, m_addr, DMA_A);
        end
        #1 rst_n = 0;
        #1;
        checks++;
        if (m_rd_en !== 1'b0 || m_addr !== 32'h0 || dma_available !== 1'b0) begin
            failures++; $display("FAIL mid_async got=%b/%h/%b exp=0/0/0", m_rd_en, m_addr, dma_available);
        end
        cpu_rd_en = 1; cpu_addr = CPU_A;
        @(negedge clk);
        rst_n = 1;
        step();
        checks++;
        if (m_rd_en !== 1'b1 || m_addr !== CPU_A) begin
            failures++; $display("FAIL mid_cpu_first got=%b/%h exp=1/%h", m_rd_en, m_addr, CPU_A);
        end
        m_available = 1; #1;
        step();
        m_available = 0; cpu_rd_en = 0; dma_rd_en = 0;
        step();
    endtask

`ifdef DMEM_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        cpu_rd_en = 1; cpu_addr = CPU_A; dma_rd_en = 1; dma_addr = DMA_A;
        step();
        m_available = 1; #1;
        step();
        m_available = 0; cpu_rd_en = 0;
        step();
        checks++;
        if (m_addr !== DMA_A || dma_wait_cnt !== 32'd3 || cpu_grant_cnt !== 32'd1 ||
            dma_grant_cnt !== 32'd1 || cpu_wait_cnt !== 32'd1) begin
            failures++; $display("FAIL perf_counts got=%h/%0d/%0d/%0d/%0d exp=%h/3/1/1/1", m_addr,
                dma_wait_cnt, cpu_grant_cnt, dma_grant_cnt, cpu_wait_cnt, DMA_A);
        end
        m_available = 1; #1;
        step();
        m_available = 0; dma_rd_en = 0; perf_clr = 1;
        step();
        perf_clr = 0; #1;
        checks++;
        if ({cpu_grant_cnt, dma_grant_cnt, cpu_wait_cnt, dma_wait_cnt} !== 128'h0) begin
            failures++; $display("FAIL perf_clr got=%0d/%0d/%0d/%0d exp=0/0/0/0",
                cpu_grant_cnt, dma_grant_cnt, cpu_wait_cnt, dma_wait_cnt);
        end
    endtask
`endif

    initial begin
        clear_inputs();
        test_reset();
        test_cpu_read();
        test_fairness();
        test_write_priority();
        test_timeout();
        test_abort();
        test_reset_mid();
`ifdef DMEM_ARB_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
